rsa_accel_wrapper: RTL and testbench

//  Command/data front-end of the RSA accelerator between the ARM interface and one 512-bit

---
 rtl/rsa_accel_wrapper.sv | 274 +++++++++++++++++++++++++++
 tb/tb_rsa_accel_wrapper.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_accel_wrapper.sv
// rtl/rsa_accel_wrapper.sv - RSA accelerator command/data front-end with Montgomery core
module montgomery (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [511:0] in_a,
    input  logic [511:0] in_b,
    input  logic [511:0] in_m,
    output logic [511:0] result,
    output logic         done
);
    // Radix-2 steps folded into one cycle; b is consumed BPC bits at a time.
    localparam int             BPC      = 32;
    localparam int             NCYC     = 512 / BPC;
    localparam logic [3:0]     CNT_LAST = 4'(NCYC - 1);

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_RED} mstate_e;

    mstate_e      st_q, st_d;
    logic [511:0] a_q, b_q, m_q, res_q;
    logic [513:0] t_q;
    logic [3:0]   cnt_q;
    logic         done_q;
    logic [514:0] t_step;
    logic [511:0] t_red;

    // BPC interleaved add-and-halve steps; T stays below 3m when a < 2m
    always_comb begin
        t_step = {1'b0, t_q};
        for (int k = 0; k < BPC; k++) begin
            if (b_q[k]) t_step = t_step + {3'b0, a_q};
            if (t_step[0]) t_step = t_step + {3'b0, m_q};
            t_step = t_step >> 1;
        end
    end

    // Final reduction of T < 3m into [0, m); the true result fits in 512 bits
    always_comb begin
        if ({1'b0, t_q} >= {2'b0, m_q, 1'b0})
            t_red = t_q[511:0] - {m_q[510:0], 1'b0};
        else if (t_q >= {2'b0, m_q})
            t_red = t_q[511:0] - m_q;
        else
            t_red = t_q[511:0];
    end

    // Core sequencing: latch on start, run NCYC step cycles, one reduce cycle
    always_comb begin
        st_d = st_q;
        case (st_q)
            M_IDLE:  if (start) st_d = M_RUN;
            M_RUN:   if (cnt_q == CNT_LAST) st_d = M_RED;
            M_RED:   st_d = M_IDLE;
            default: st_d = M_IDLE;
        endcase
    end

    // Core state and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q   <= M_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            t_q    <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            done_q <= (st_q == M_RED);
            if (st_q == M_IDLE && start) begin
                a_q   <= in_a;
                b_q   <= in_b;
                m_q   <= in_m;
                t_q   <= '0;
                cnt_q <= '0;
            end
            if (st_q == M_RUN) begin
                t_q   <= t_step[513:0];
                b_q   <= b_q >> BPC;
                cnt_q <= cnt_q + 4'd1;
            end
            if (st_q == M_RED) res_q <= t_red;
        end
    end

    assign result = res_q;
    assign done   = done_q;
endmodule

module rsa_accel_wrapper (
    input  logic          clk,
    input  logic          resetn,
    input  logic [31:0]   arm_to_fpga_cmd,
    input  logic          arm_to_fpga_cmd_valid,
    output logic          fpga_to_arm_done,
    input  logic          fpga_to_arm_done_read,
    input  logic          arm_to_fpga_data_valid,
    output logic          arm_to_fpga_data_ready,
    input  logic [1023:0] arm_to_fpga_data,
    output logic          fpga_to_arm_data_valid,
    input  logic          fpga_to_arm_data_ready,
    output logic [1023:0] fpga_to_arm_data,
    output logic [3:0]    leds
);
    localparam logic [31:0] CMD_EXP    = 32'd0;
    localparam logic [31:0] CMD_MONT   = 32'd1;
    localparam logic [31:0] CMD_RD_MOD = 32'd2;
    localparam logic [31:0] CMD_RD_RSQ = 32'd3;
    localparam logic [31:0] CMD_RD_EXP = 32'd4;
    localparam logic [31:0] CMD_WRITE  = 32'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_TX, S_DONE, S_INIT, S_SQUARE, S_MULT, S_FINAL
    } state_e;

    state_e       state_q, state_d;
    logic [2:0]   cmd_q;
    logic         exp_mode_q;
    logic [511:0] m_q, hi_q, lo_q, rm_q, e_q, xt_q, acc_q, res_q, out_q;
    logic [8:0]   bit_q;
    logic         done_q, rdy_q, oval_q, core_start_q, core_start_d;
    logic [3:0]   leds_q, leds_d;
    logic [511:0] core_a, core_b, core_res;
    logic         core_done;

    // Main FSM: command dispatch, handshakes and square-and-multiply sequencing
    always_comb begin
        state_d      = state_q;
        core_start_d = 1'b0;
        case (state_q)
            S_IDLE: if (arm_to_fpga_cmd_valid) begin
                case (arm_to_fpga_cmd)
                    CMD_RD_MOD, CMD_RD_RSQ, CMD_RD_EXP: state_d = S_RX;
                    CMD_EXP, CMD_MONT: begin
                        state_d      = S_INIT;
                        core_start_d = 1'b1;
                    end
                    CMD_WRITE: state_d = S_TX;
                    default:   state_d = S_DONE;
                endcase
            end
            S_RX:   if (arm_to_fpga_data_valid) state_d = S_DONE;
            S_TX:   if (fpga_to_arm_data_ready) state_d = S_DONE;
            S_DONE: if (fpga_to_arm_done_read) state_d = S_IDLE;
            S_INIT: if (core_done) begin
                if (exp_mode_q) begin
                    state_d      = S_SQUARE;
                    core_start_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SQUARE: if (core_done) begin
                core_start_d = 1'b1;
                if (e_q[bit_q])        state_d = S_MULT;
                else if (bit_q == 9'd0) state_d = S_FINAL;
                else                   state_d = S_SQUARE;
            end
            S_MULT: if (core_done) begin
                core_start_d = 1'b1;
                state_d      = (bit_q == 9'd0) ? S_FINAL : S_SQUARE;
            end
            S_FINAL: if (core_done) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // One-hot state indication for the board LEDs
    always_comb begin
        case (state_d)
            S_IDLE:        leds_d = 4'b0001;
            S_RX:          leds_d = 4'b0010;
            S_TX, S_DONE:  leds_d = 4'b1000;
            default:       leds_d = 4'b0100;
        endcase
    end

    // Core operand selection for the current compute step
    always_comb begin
        case (state_q)
            S_SQUARE: begin core_a = acc_q; core_b = acc_q;  end
            S_MULT:   begin core_a = acc_q; core_b = xt_q;   end
            S_FINAL:  begin core_a = acc_q; core_b = 512'd1; end
            default:  begin core_a = hi_q;  core_b = lo_q;   end
        endcase
    end

    // State, handshake outputs, operand latching and compute results
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            exp_mode_q   <= 1'b0;
            m_q          <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            rm_q         <= '0;
            e_q          <= '0;
            xt_q         <= '0;
            acc_q        <= '0;
            res_q        <= '0;
            out_q        <= '0;
            bit_q        <= '0;
            done_q       <= 1'b0;
            rdy_q        <= 1'b0;
            oval_q       <= 1'b0;
            core_start_q <= 1'b0;
            leds_q       <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            leds_q       <= leds_d;
            done_q       <= (state_d == S_DONE);
            rdy_q        <= (state_q == S_RX) && arm_to_fpga_data_valid;
            oval_q       <= (state_q == S_TX) && fpga_to_arm_data_ready;
            if (state_q == S_IDLE && arm_to_fpga_cmd_valid) begin
                cmd_q      <= arm_to_fpga_cmd[2:0];
                exp_mode_q <= (arm_to_fpga_cmd == CMD_EXP);
            end
            if (state_q == S_RX && arm_to_fpga_data_valid) begin
                if (cmd_q == CMD_RD_MOD[2:0]) m_q <= arm_to_fpga_data[511:0];
                if (cmd_q == CMD_RD_RSQ[2:0]) begin
                    hi_q <= arm_to_fpga_data[1023:512];
                    lo_q <= arm_to_fpga_data[511:0];
                end
                if (cmd_q == CMD_RD_EXP[2:0]) begin
                    rm_q <= arm_to_fpga_data[1023:512];
                    e_q  <= arm_to_fpga_data[511:0];
                end
            end
            if (state_q == S_TX && fpga_to_arm_data_ready) out_q <= res_q;
            if (core_done) begin
                case (state_q)
                    S_INIT: if (exp_mode_q) begin
                        xt_q  <= core_res;
                        acc_q <= rm_q;
                        bit_q <= 9'd511;
                    end else begin
                        res_q <= core_res;
                    end
                    S_SQUARE: begin
                        acc_q <= core_res;
                        if (!e_q[bit_q] && bit_q != 9'd0) bit_q <= bit_q - 9'd1;
                    end
                    S_MULT: begin
                        acc_q <= core_res;
                        if (bit_q != 9'd0) bit_q <= bit_q - 9'd1;
                    end
                    S_FINAL: res_q <= core_res;
                    default: ;
                endcase
            end
        end
    end

    montgomery u_mont (
        .clk    (clk),
        .resetn (resetn),
        .start  (core_start_q),
        .in_a   (core_a),
        .in_b   (core_b),
        .in_m   (m_q),
        .result (core_res),
        .done   (core_done)
    );

    assign fpga_to_arm_done       = done_q;
    assign arm_to_fpga_data_ready = rdy_q;
    assign fpga_to_arm_data_valid = oval_q;
    assign fpga_to_arm_data       = {512'b0, out_q};
    assign leds                   = leds_q;
endmodule

// File: tb/tb_rsa_accel_wrapper.sv
// tb/tb_rsa_accel_wrapper.sv - directed self-checking bench for rsa_accel_wrapper
module tb_rsa_accel_wrapper;
    localparam logic [31:0] CMD_EXP    = 32'd0;
    localparam logic [31:0] CMD_MONT   = 32'd1;
    localparam logic [31:0] CMD_RD_MOD = 32'd2;
    localparam logic [31:0] CMD_RD_RSQ = 32'd3;
    localparam logic [31:0] CMD_RD_EXP = 32'd4;
    localparam logic [31:0] CMD_WRITE  = 32'd5;

    logic          clk = 1'b0;
    logic          resetn;
    logic [31:0]   arm_to_fpga_cmd;
    logic          arm_to_fpga_cmd_valid;
    logic          fpga_to_arm_done;
    logic          fpga_to_arm_done_read;
    logic          arm_to_fpga_data_valid;
    logic          arm_to_fpga_data_ready;
    logic [1023:0] arm_to_fpga_data;
    logic          fpga_to_arm_data_valid;
    logic          fpga_to_arm_data_ready;
    logic [1023:0] fpga_to_arm_data;
    logic [3:0]    leds;

    int n_tests = 0;
    int n_fail  = 0;

    logic [511:0]  all1, m_p3, p511, p510, p175;
    logic [1023:0] rd;
    int            rdy_cnt;

    always #5 clk = ~clk;

    rsa_accel_wrapper dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .arm_to_fpga_cmd        (arm_to_fpga_cmd),
        .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
        .fpga_to_arm_done       (fpga_to_arm_done),
        .fpga_to_arm_done_read  (fpga_to_arm_done_read),
        .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
        .arm_to_fpga_data       (arm_to_fpga_data),
        .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
        .fpga_to_arm_data       (fpga_to_arm_data),
        .leds                   (leds)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] c);
        arm_to_fpga_cmd       = c;
        arm_to_fpga_cmd_valid = 1'b1;
        @(negedge clk);
        arm_to_fpga_cmd_valid = 1'b0;
    endtask

    task automatic finish_done(input string tag, input int budget);
        int n = 0;
        while (!fpga_to_arm_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, 512'(fpga_to_arm_done), 512'd1);
        fpga_to_arm_done_read = 1'b1;
        @(negedge clk);
        fpga_to_arm_done_read = 1'b0;
        check_eq({tag, "_done_clr"}, 512'(fpga_to_arm_done), 512'd0);
    endtask

    task automatic load(input logic [31:0] c, input logic [511:0] hi, input logic [511:0] lo);
        int n = 0;
        send_cmd(c);
        arm_to_fpga_data       = {hi, lo};
        arm_to_fpga_data_valid = 1'b1;
        while (!arm_to_fpga_data_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("load_ready", 512'(arm_to_fpga_data_ready), 512'd1);
        arm_to_fpga_data_valid = 1'b0;
        finish_done("load", 20);
    endtask

    task automatic compute(input logic [31:0] c);
        send_cmd(c);
        check_eq("compute_leds", 512'(leds), 512'h4);
        finish_done("compute", 20000);
    endtask

    task automatic read_result(output logic [1023:0] r);
        int n = 0;
        send_cmd(CMD_WRITE);
        fpga_to_arm_data_ready = 1'b1;
        while (!fpga_to_arm_data_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("tx_valid", 512'(fpga_to_arm_data_valid), 512'd1);
        r = fpga_to_arm_data;
        fpga_to_arm_data_ready = 1'b0;
        finish_done("tx", 20);
    endtask

    task automatic expect_result(input string tag, input logic [511:0] exp);
        read_result(rd);
        check_eq({tag, "_lo"}, rd[511:0], exp);
        check_eq({tag, "_hi"}, rd[1023:512], 512'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        all1 = '1;
        m_p3 = all1 - 512'd2;
        p511 = 512'd1 << 511;
        p510 = 512'd1 << 510;
        p175 = 512'd1 << 175;
        resetn                 = 1'b0;
        arm_to_fpga_cmd        = '0;
        arm_to_fpga_cmd_valid  = 1'b0;
        fpga_to_arm_done_read  = 1'b0;
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = '0;
        fpga_to_arm_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_done", 512'(fpga_to_arm_done), 512'd0);
        check_eq("rst_ready", 512'(arm_to_fpga_data_ready), 512'd0);
        check_eq("rst_ovalid", 512'(fpga_to_arm_data_valid), 512'd0);
        check_eq("rst_leds", 512'(leds), 512'd0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("idle_leds", 512'(leds), 512'h1);

        // input handshake: valid held for 5 cycles yields a single ready
        send_cmd(CMD_RD_MOD);
        check_eq("rx_leds", 512'(leds), 512'h2);
        repeat (2) @(negedge clk);
        check_eq("rx_wait_ready", 512'(arm_to_fpga_data_ready), 512'd0);
        arm_to_fpga_data       = {512'd0, 512'd257};
        arm_to_fpga_data_valid = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (arm_to_fpga_data_ready) rdy_cnt++;
        end
        arm_to_fpga_data_valid = 1'b0;
        check_eq("rx_ready_cycles", 512'(rdy_cnt), 512'd1);
        check_eq("rx_done_leds", 512'(leds), 512'h8);
        repeat (4) @(negedge clk);
        check_eq("done_hold", 512'(fpga_to_arm_done), 512'd1);
        fpga_to_arm_done_read = 1'b1;
        @(negedge clk);
        fpga_to_arm_done_read = 1'b0;
        check_eq("done_ack", 512'(fpga_to_arm_done), 512'd0);
        check_eq("ack_leds", 512'(leds), 512'h1);

        // M=257 has R = 2^512 = 1 mod M, so MONT(a,b) = a*b mod 257
        load(CMD_RD_RSQ, 512'd300, 512'd200);
        compute(CMD_MONT);
        expect_result("mont257", 512'd119);

        // M=65537 also has R = 1; A exceeds M but stays below 2M
        load(CMD_RD_MOD, 512'd0, 512'd65537);
        load(CMD_RD_RSQ, 512'd70000, 512'd3);
        compute(CMD_MONT);
        expect_result("mont65537", 512'd13389);

        // M=2^512-1: R = 1 mod M, full-width operands
        load(CMD_RD_MOD, 512'd0, all1);
        load(CMD_RD_RSQ, all1 - 512'd1, all1 - 512'd1);
        compute(CMD_MONT);
        expect_result("mont_neg1sq", 512'd1);
        load(CMD_RD_RSQ, p511, p511);
        compute(CMD_MONT);
        expect_result("mont_p511sq", p510);

        // M=2^512-3: R = 3 mod M, R^2 = 9, MONT(a,b) = a*b/3 mod M
        load(CMD_RD_MOD, 512'd0, m_p3);
        load(CMD_RD_RSQ, 512'd6, 512'd9);
        compute(CMD_MONT);
        expect_result("mont_m3", 512'd18);

        // exponentiation: 2^0xaf, E=0, E=1 with x=5
        load(CMD_RD_EXP, 512'd3, 512'haf);
        load(CMD_RD_RSQ, 512'd2, 512'd9);
        compute(CMD_EXP);
        expect_result("exp_2_175", p175);
        load(CMD_RD_EXP, 512'd3, 512'd0);
        compute(CMD_EXP);
        expect_result("exp_e0", 512'd1);
        load(CMD_RD_EXP, 512'd3, 512'd1);
        load(CMD_RD_RSQ, 512'd5, 512'd9);
        compute(CMD_EXP);
        expect_result("exp_e1", 512'd5);

        // 3^175 mod 257 = 85
        load(CMD_RD_MOD, 512'd0, 512'd257);
        load(CMD_RD_EXP, 512'd1, 512'haf);
        load(CMD_RD_RSQ, 512'd3, 512'd1);
        compute(CMD_EXP);
        expect_result("exp_257", 512'd85);

        // unknown command: straight to done, no handshake, result kept;
        // a command issued while in DONE is ignored
        send_cmd(32'd7);
        check_eq("unk_done", 512'(fpga_to_arm_done), 512'd1);
        check_eq("unk_leds", 512'(leds), 512'h8);
        check_eq("unk_ready", 512'(arm_to_fpga_data_ready), 512'd0);
        send_cmd(CMD_MONT);
        check_eq("busy_cmd_leds", 512'(leds), 512'h8);
        finish_done("unk", 20);
        check_eq("unk_idle_leds", 512'(leds), 512'h1);
        expect_result("unk_keep", 512'd85);

        // reset in the middle of an exponentiation
        send_cmd(CMD_EXP);
        repeat (300) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_done", 512'(fpga_to_arm_done), 512'd0);
        check_eq("mid_rst_ready", 512'(arm_to_fpga_data_ready), 512'd0);
        check_eq("mid_rst_ovalid", 512'(fpga_to_arm_data_valid), 512'd0);
        check_eq("mid_rst_leds", 512'(leds), 512'd0);
        check_eq("mid_rst_data", fpga_to_arm_data[511:0], 512'd0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_leds", 512'(leds), 512'h1);
        expect_result("post_rst_res", 512'd0);
        load(CMD_RD_MOD, 512'd0, 512'd257);
        load(CMD_RD_RSQ, 512'd300, 512'd200);
        compute(CMD_MONT);
        expect_result("post_rst_mont", 512'd119);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
